// File: rtl/reset_route_sequencer.sv
// Brings reset routes up in index order and tears them down in reverse order,
// one route at a time with a settle gap, watching each ack edge with a timeout.
module reset_route_sequencer #(
  parameter int NUM_ROUTES         = 4,
  parameter int SETTLE_CYCLES      = 4,
  parameter int ACK_TIMEOUT_CYCLES = 64,
  localparam int IDX_W = (NUM_ROUTES > 1) ? $clog2(NUM_ROUTES) : 1
) (
  input  logic                  clock,
  input  logic                  async_resetn,
  input  logic                  run_req,
  output logic                  run_ack,
  output logic                  busy,
  output logic [NUM_ROUTES-1:0] route_enable_req,
  input  logic [NUM_ROUTES-1:0] route_enable_ack,
  output logic [IDX_W-1:0]      current_route,
  output logic                  timeout_err,
  output logic [IDX_W-1:0]      err_route
);

  localparam int TMR_MAX = (ACK_TIMEOUT_CYCLES > SETTLE_CYCLES) ? ACK_TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ROUTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UP_REQ, S_UP_SETTLE, S_RUN, S_DOWN_REQ, S_DOWN_SETTLE, S_FAULT
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d, err_q, err_d, drop_idx;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic                    terr_q, terr_d, run_ack_q, run_ack_d, busy_q, busy_d;
  logic [NUM_ROUTES-1:0]   req_q, req_d;
  logic                    ack_cur, timeout_hit, settle_done;

  function automatic logic [NUM_ROUTES-1:0] low_mask(input logic [IDX_W:0] n);
    logic [NUM_ROUTES-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_ROUTES; i++) m[i] = (i < int'(n));
    return m;
  endfunction

  assign ack_cur     = route_enable_ack[idx_q];
  assign timeout_hit = (tmr_q == TMR_W'(ACK_TIMEOUT_CYCLES - 1));
  assign settle_done = (tmr_q == TMR_W'(SETTLE_CYCLES - 1));

  // Lowest index whose ack has fallen while everything should be up
  always_comb begin
    drop_idx = '0;
    for (int i = NUM_ROUTES - 1; i >= 0; i--)
      if (!route_enable_ack[i]) drop_idx = IDX_W'(i);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    terr_d  = terr_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: if (run_req) begin
        state_d = S_UP_REQ;
        idx_d   = '0;
        terr_d  = 1'b0;
      end
      S_UP_REQ: begin
        if (timeout_hit && !ack_cur) begin
          state_d = S_FAULT;
          err_d   = idx_q;
        end else if (ack_cur)  state_d = S_UP_SETTLE;
        else if (!run_req)     state_d = S_DOWN_REQ;
      end
      S_UP_SETTLE: begin
        if (!run_req) state_d = S_DOWN_REQ;
        else if (settle_done) begin
          if (idx_q == LAST) state_d = S_RUN;
          else begin
            state_d = S_UP_REQ;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (route_enable_ack != '1) begin
          state_d = S_FAULT;
          err_d   = drop_idx;
        end else if (!run_req) begin
          state_d = S_DOWN_REQ;
          idx_d   = LAST;
        end
      end
      S_DOWN_REQ: begin
        if (timeout_hit && ack_cur) begin
          state_d = S_FAULT;
          err_d   = idx_q;
        end else if (!ack_cur) state_d = S_DOWN_SETTLE;
      end
      S_DOWN_SETTLE: if (settle_done) begin
        if (idx_q == '0) state_d = S_IDLE;
        else begin
          state_d = S_DOWN_REQ;
          idx_d   = idx_q - 1'b1;
        end
      end
      S_FAULT: if (!run_req && route_enable_ack == '0) begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_FAULT && state_d == S_FAULT) terr_d = 1'b1;

    // Outputs are registered from the state being entered
    tmr_d = (state_d != state_q) ? '0 :
            (tmr_q == TMR_W'(TMR_MAX)) ? tmr_q : tmr_q + 1'b1;
    unique case (state_d)
      S_UP_REQ, S_UP_SETTLE:     req_d = low_mask({1'b0, idx_d} + 1'b1);
      S_RUN:                     req_d = '1;
      S_DOWN_REQ, S_DOWN_SETTLE: req_d = low_mask({1'b0, idx_d});
      default:                   req_d = '0;
    endcase
    run_ack_d = (state_d == S_RUN);
    busy_d    = (state_d == S_UP_REQ) || (state_d == S_UP_SETTLE) ||
                (state_d == S_DOWN_REQ) || (state_d == S_DOWN_SETTLE);
  end

  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      tmr_q     <= '0;
      terr_q    <= 1'b0;
      err_q     <= '0;
      req_q     <= '0;
      run_ack_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tmr_q     <= tmr_d;
      terr_q    <= terr_d;
      err_q     <= err_d;
      req_q     <= req_d;
      run_ack_q <= run_ack_d;
      busy_q    <= busy_d;
    end
  end

  assign route_enable_req = req_q;
  assign run_ack          = run_ack_q;
  assign busy             = busy_q;
  assign current_route    = idx_q;
  assign timeout_err      = terr_q;
  assign err_route        = err_q;

endmodule

// File: tb/tb_reset_route_sequencer.sv
// Bench for reset_route_sequencer: directed scenarios plus random run_req/ack
// disturbances, every cycle compared against a behavioural reference model.
module tb_reset_route_sequencer;
  localparam int N = 3, S = 4, T = 64, DLY = 35;
  localparam int P_IDLE = 0, P_UPR = 1, P_UPS = 2, P_RUN = 3, P_DNR = 4, P_DNS = 5, P_FLT = 6;

  logic         clock = 1'b0, async_resetn = 1'b0, run_req = 1'b0;
  logic [N-1:0] ack = '0;
  logic [N-1:0] route_enable_req;
  logic         run_ack, busy, timeout_err;
  logic [1:0]   current_route, err_route;

  reset_route_sequencer #(.NUM_ROUTES(N), .SETTLE_CYCLES(S), .ACK_TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .async_resetn(async_resetn), .run_req(run_req), .run_ack(run_ack),
    .busy(busy), .route_enable_req(route_enable_req), .route_enable_ack(ack),
    .current_route(current_route), .timeout_err(timeout_err), .err_route(err_route));

  always #5 clock = ~clock;

  int total = 0, bad = 0;
  int ph = P_IDLE, mi = 0, mt = 0, mer = 0;
  bit me = 0;
  logic [N-1:0] drop = '0, stuck = '0;
  logic [N-1:0] dq[$];

  // Expected request pattern: the first k routes up
  function automatic logic [N-1:0] first_k(int k);
    return N'((1 << k) - 1);
  endfunction

  function automatic logic [N-1:0] exp_req();
    case (ph)
      P_UPR, P_UPS: return first_k(mi + 1);
      P_RUN:        return first_k(N);
      P_DNR, P_DNS: return first_k(mi);
      default:      return '0;
    endcase
  endfunction

  task automatic model_reset();
    ph = P_IDLE; mi = 0; mt = 0; me = 0; mer = 0;
  endtask

  task automatic model_edge();
    int np = ph;
    int ni = mi;
    case (ph)
      P_IDLE: if (run_req) begin np = P_UPR; ni = 0; me = 0; end
      P_UPR:
        if (mt == T - 1 && !ack[mi]) begin np = P_FLT; mer = mi; end
        else if (ack[mi]) np = P_UPS;
        else if (!run_req) np = P_DNR;
      P_UPS:
        if (!run_req) np = P_DNR;
        else if (mt == S - 1) begin
          if (mi == N - 1) np = P_RUN;
          else begin np = P_UPR; ni = mi + 1; end
        end
      P_RUN:
        if (ack != first_k(N)) begin
          np = P_FLT;
          for (int i = N - 1; i >= 0; i--) if (!ack[i]) mer = i;
        end else if (!run_req) begin np = P_DNR; ni = N - 1; end
      P_DNR:
        if (mt == T - 1 && ack[mi]) begin np = P_FLT; mer = mi; end
        else if (!ack[mi]) np = P_DNS;
      P_DNS:
        if (mt == S - 1) begin
          if (mi == 0) np = P_IDLE;
          else begin np = P_DNR; ni = mi - 1; end
        end
      default:
        if (!run_req && ack == '0) begin np = P_IDLE; ni = 0; end
    endcase
    if (np == P_FLT && ph != P_FLT) me = 1;
    mt = (np != ph) ? 0 : mt + 1;
    ph = np;
    mi = ni;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("req", 32'(route_enable_req), 32'(exp_req()));
    chk("run_ack", 32'(run_ack), 32'(ph == P_RUN));
    chk("busy", 32'(busy), 32'(ph == P_UPR || ph == P_UPS || ph == P_DNR || ph == P_DNS));
    chk("current_route", 32'(current_route), 32'(mi));
    chk("timeout_err", 32'(timeout_err), 32'(me));
    chk("err_route", 32'(err_route), 32'(mer));
  endtask

  // One clock: advance model, compare, then let the route blocks answer
  task automatic step();
    logic [N-1:0] d;
    if (async_resetn) model_edge(); else model_reset();
    @(posedge clock); #1;
    check_all();
    d = '0;
    if (!async_resetn) dq.delete();
    else begin
      dq.push_back(exp_req());
      if (dq.size() > DLY) d = dq.pop_front();
    end
    ack = d & ~drop & ~stuck;
  endtask

  task automatic run_until(int p, int idx, int budget, string tag);
    int n = 0;
    while (!(ph == p && (idx < 0 || mi == idx)) && n < budget) begin step(); n++; end
    total++;
    assert (n < budget) else begin
      bad++;
      $error("FAIL %s wait expired observed_phase=%0d required_phase=%0d", tag, ph, p);
    end
  endtask

  task automatic wait_req(logic [N-1:0] v, output int n);
    n = 0;
    while (route_enable_req !== v && n < 300) begin step(); n++; end
  endtask

  initial begin
    int n;
    repeat (3) step();
    check_all();
    chk("rst_req", 32'(route_enable_req), 32'h0);
    async_resetn = 1'b1;
    repeat (3) step();

    // Bring-up spacing and RUN entry
    run_req = 1'b1;
    step();
    chk("t1_req0", 32'(route_enable_req), 32'h1);
    wait_req(3'b011, n); chk("t1_gap01", 32'(n), 32'd40);
    wait_req(3'b111, n); chk("t1_gap12", 32'(n), 32'd40);
    n = 0;
    while (run_ack !== 1'b1 && n < 300) begin step(); n++; end
    chk("t1_run_gap", 32'(n), 32'd40);
    chk("t1_busy", 32'(busy), 32'h0);

    // Reverse teardown
    run_req = 1'b0;
    step();
    chk("t2_run_ack", 32'(run_ack), 32'h0);
    chk("t2_req2", 32'(route_enable_req), 32'h3);
    wait_req(3'b001, n); chk("t2_gap21", 32'(n), 32'd40);
    wait_req(3'b000, n); chk("t2_gap10", 32'(n), 32'd40);
    n = 0;
    while (busy !== 1'b0 && n < 300) begin step(); n++; end
    chk("t2_idle_gap", 32'(n), 32'd40);

    // Route 1 never acks
    stuck = 3'b010;
    run_req = 1'b1;
    wait_req(3'b011, n);
    wait_req(3'b000, n); chk("t3_timeout", 32'(n), 32'd64);
    chk("t3_terr", 32'(timeout_err), 32'h1);
    chk("t3_err_route", 32'(err_route), 32'h1);
    repeat (10) step();
    chk("t3_hold", 32'(timeout_err), 32'h1);
    run_req = 1'b0;
    run_until(P_IDLE, -1, 200, "t3_exit");
    stuck = '0;
    run_req = 1'b1;
    step();
    chk("t3_clear", 32'(timeout_err), 32'h0);
    run_until(P_RUN, -1, 300, "t3_run");
    run_req = 1'b0;
    run_until(P_IDLE, -1, 300, "t3_idle");

    // Abort during UP_REQ of route 1, then an ignored pulse
    run_req = 1'b1;
    run_until(P_UPR, 1, 200, "t4_up1");
    repeat ($urandom_range(0, 20)) step();
    run_req = 1'b0;
    step();
    chk("t4_drop1", 32'(route_enable_req), 32'h1);
    run_until(P_DNR, 0, 200, "t4_dn0");
    chk("t4_drop0", 32'(route_enable_req), 32'h0);
    run_req = 1'b1; step(); step(); run_req = 1'b0;
    run_until(P_IDLE, -1, 200, "t4_idle");
    chk("t4_busy", 32'(busy), 32'h0);

    // Ack loss in RUN
    run_req = 1'b1;
    run_until(P_RUN, -1, 300, "t5_run");
    drop = 3'b010;
    ack = ack & ~drop;
    step();
    chk("t5_err_route", 32'(err_route), 32'h1);
    chk("t5_req", 32'(route_enable_req), 32'h0);
    chk("t5_run_ack", 32'(run_ack), 32'h0);
    drop = '0;
    run_req = 1'b0;
    run_until(P_IDLE, -1, 200, "t5_idle");

    // Async reset mid UP_SETTLE of the last route
    run_req = 1'b1;
    run_until(P_UPS, 2, 300, "t6_ups2");
    step();
    #2 async_resetn = 1'b0;
    #1;
    model_reset();
    dq.delete();
    ack = '0;
    chk("t6_req", 32'(route_enable_req), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_route", 32'(current_route), 32'h0);
    repeat (3) step();
    async_resetn = 1'b1;
    step();
    chk("t6_restart", 32'(route_enable_req), 32'h1);
    run_until(P_RUN, -1, 300, "t6_run");

    // Random run_req toggling and ack disturbances
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 59) == 0) run_req = ~run_req;
      if (drop != '0 && $urandom_range(0, 7) == 0) drop = '0;
      else if ($urandom_range(0, 299) == 0) drop = N'($urandom_range(1, 7));
      ack = ack & ~drop;
      step();
    end
    drop = '0;
    run_req = 1'b0;
    run_until(P_IDLE, -1, 1000, "rand_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
